// File: rtl/disable_timing_pkg.sv
// Shared types and default parameters for the disable-timing capture/checker stage.
package disable_timing_pkg;

    // Default synchronizer depth; two flops is the minimum for metastability settling.
    localparam int unsigned SYNC_STAGES_DEF = 2;
    // Default number of compare cycles per run.
    localparam int unsigned WINDOW_DEF      = 256;
    // Default width of the error and edge counters.
    localparam int unsigned CNT_W_DEF       = 16;

    // Run controller states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/disable_timing_capture_if.sv
// Handshake/bus bundle for the capture stage: run control, sampled taps and results.
interface disable_timing_capture_if
    import disable_timing_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             start;
    logic             d_in_1;
    logic             d_in_2;
    logic             y_comb;
    logic             q_reg;
    logic             busy;
    logic             done;
    logic             sticky_err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] edge_cnt;

    // Driver side: issues start and presents the tapped signals.
    modport master (
        output start,
        output d_in_1,
        output d_in_2,
        output y_comb,
        output q_reg,
        input  busy,
        input  done,
        input  sticky_err,
        input  err_cnt,
        input  edge_cnt
    );

    // Checker side: the capture stage itself.
    modport slave (
        input  start,
        input  d_in_1,
        input  d_in_2,
        input  y_comb,
        input  q_reg,
        output busy,
        output done,
        output sticky_err,
        output err_cnt,
        output edge_cnt
    );

endinterface

// File: rtl/sync_chain.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
module sync_chain #(
    parameter int unsigned Stages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    // Shift the sampled input through the flop chain; reset clears every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/disable_timing_capture.sv
// Downstream capture/checker for the disable-timing benchmark. Synchronizes the
// AND output, the registered output and both data taps, then over a fixed window
// counts functional mismatches and rising edges of the synchronized AND output.
module disable_timing_capture
    import disable_timing_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned WINDOW      = WINDOW_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input logic                     clk,
    input logic                     rst_n,
    disable_timing_capture_if.slave cap_io
);

    localparam int unsigned    WinW     = $clog2(WINDOW + 1);
    localparam int unsigned    FillW    = $clog2(SYNC_STAGES + 1);
    localparam logic [WinW-1:0]  WinLast  = WinW'(WINDOW - 1);
    localparam logic [FillW-1:0] FillLast = FillW'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    // Synchronized copies of every sampled input.
    logic a_s;
    logic b_s;
    logic y_s;
    logic q_s;

    // History of the previous synchronized a and y.
    logic a_p_q;
    logic y_p_q;

    state_e           state_q, state_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [WinW-1:0]  win_q, win_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             sticky_q, sticky_d;

    logic mismatch;
    logic rise;

    sync_chain #(.Stages(SYNC_STAGES)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cap_io.d_in_1),
        .q_o   (a_s)
    );

    sync_chain #(.Stages(SYNC_STAGES)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cap_io.d_in_2),
        .q_o   (b_s)
    );

    sync_chain #(.Stages(SYNC_STAGES)) u_sync_y (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cap_io.y_comb),
        .q_o   (y_s)
    );

    sync_chain #(.Stages(SYNC_STAGES)) u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cap_io.q_reg),
        .q_o   (q_s)
    );

    // History flops run freely; FILL guarantees they hold in-run data by the first compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p_q <= 1'b0;
            y_p_q <= 1'b0;
        end else begin
            a_p_q <= a_s;
            y_p_q <= y_s;
        end
    end

    // AND result must match the synchronized inputs; the register must echo last cycle's a.
    assign mismatch = (y_s != (a_s & b_s)) || (q_s != a_p_q);
    assign rise     = y_s & ~y_p_q;

    // Next-state logic for the run controller, window/fill counters and result counters.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        win_d      = win_q;
        err_cnt_d  = err_cnt_q;
        edge_cnt_d = edge_cnt_q;
        sticky_d   = sticky_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (cap_io.start) begin
                    state_d    = StFill;
                    fill_d     = '0;
                    win_d      = '0;
                    err_cnt_d  = '0;
                    edge_cnt_d = '0;
                    sticky_d   = 1'b0;
                end
            end
            StFill: begin
                // start is deliberately ignored here and in RUN.
                if (fill_q == FillLast) begin
                    state_d = StRun;
                end else begin
                    fill_d = fill_q + FillW'(1);
                end
            end
            StRun: begin
                if (mismatch) begin
                    sticky_d = 1'b1;
                    if (err_cnt_q != CntMax) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
                if (rise && (edge_cnt_q != CntMax)) begin
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
                win_d = win_q + WinW'(1);
                if (win_q == WinLast) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers; reset is valid at any time, including mid-run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fill_q     <= '0;
            win_q      <= '0;
            err_cnt_q  <= '0;
            edge_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            win_q      <= win_d;
            err_cnt_q  <= err_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    // Outputs come straight from registers so no input reaches an output combinationally.
    assign cap_io.busy       = (state_q == StFill) || (state_q == StRun);
    assign cap_io.done       = (state_q == StDone);
    assign cap_io.sticky_err = sticky_q;
    assign cap_io.err_cnt    = err_cnt_q;
    assign cap_io.edge_cnt   = edge_cnt_q;

endmodule

// File: tb/tb_disable_timing_capture.sv
// Directed bench for disable_timing_capture: clean run, AND and register faults,
// last-cycle fault with ignored mid-run start, mid-run reset and counter saturation.
module tb_disable_timing_capture;

    localparam int unsigned Sync    = 2;
    localparam int unsigned Win     = 8;
    localparam int unsigned CntW    = 16;
    localparam int unsigned SatWin  = 20;
    localparam int unsigned SatCntW = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    disable_timing_capture_if #(.CNT_W(CntW))    cap_if ();
    disable_timing_capture_if #(.CNT_W(SatCntW)) sat_if ();

    disable_timing_capture #(
        .SYNC_STAGES (Sync),
        .WINDOW      (Win),
        .CNT_W       (CntW)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap_io (cap_if)
    );

    disable_timing_capture #(
        .SYNC_STAGES (Sync),
        .WINDOW      (SatWin),
        .CNT_W       (SatCntW)
    ) u_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap_io (sat_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input logic y, input logic q);
        cap_if.d_in_1 = a;
        cap_if.d_in_2 = b;
        cap_if.y_comb = y;
        cap_if.q_reg  = q;
    endtask

    // Bit i of each vector is the value sampled at edge k+i, where k is the start edge.
    task automatic run_win(input string name, input logic [8:0] av, input logic [8:0] bv,
                           input logic [8:0] yv, input logic [8:0] qv, input bit mid_start);
        @(negedge clk);
        cap_if.start = 1'b1;
        drive(av[0], bv[0], yv[0], qv[0]);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            cap_if.start = mid_start && (i == 5);
            drive(av[i], bv[i], yv[i], qv[i]);
            if (i == 1) begin
                check_eq({name, ".busy_k1"},  32'(cap_if.busy),       32'd1);
                check_eq({name, ".done_k1"},  32'(cap_if.done),       32'd0);
                check_eq({name, ".err_clr"},  32'(cap_if.err_cnt),    32'd0);
                check_eq({name, ".edge_clr"}, 32'(cap_if.edge_cnt),   32'd0);
                check_eq({name, ".stk_clr"},  32'(cap_if.sticky_err), 32'd0);
            end
        end
        cap_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq({name, ".done_k9"}, 32'(cap_if.done), 32'd0);
        check_eq({name, ".busy_k9"}, 32'(cap_if.busy), 32'd1);
        @(negedge clk);
        check_eq({name, ".done_k10"}, 32'(cap_if.done), 32'd1);
        check_eq({name, ".busy_k10"}, 32'(cap_if.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cap_if.start = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        sat_if.start  = 1'b0;
        sat_if.d_in_1 = 1'b0;
        sat_if.d_in_2 = 1'b0;
        sat_if.y_comb = 1'b0;
        sat_if.q_reg  = 1'b0;
        #12;
        check_eq("rst.busy",   32'(cap_if.busy),       32'd0);
        check_eq("rst.done",   32'(cap_if.done),       32'd0);
        check_eq("rst.sticky", 32'(cap_if.sticky_err), 32'd0);
        check_eq("rst.err",    32'(cap_if.err_cnt),    32'd0);
        check_eq("rst.edge",   32'(cap_if.edge_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle.busy", 32'(cap_if.busy), 32'd0);

        // a=0 1 1 0 1 1 1 0 1, b=1 1 0 1 1 1 0 1 1, y=a&b, q=a delayed: three rises of y.
        run_win("clean", 9'b101110110, 9'b110111011, 9'b100110010, 9'b011101100, 1'b0);
        check_eq("clean.err",    32'(cap_if.err_cnt),    32'd0);
        check_eq("clean.edge",   32'(cap_if.edge_cnt),   32'd3);
        check_eq("clean.sticky", 32'(cap_if.sticky_err), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("hold.done", 32'(cap_if.done), 32'd1);
        check_eq("hold.edge", 32'(cap_if.edge_cnt), 32'd3);

        // a=0, y forced high for compares 3..5: three errors and one rise in the same cycle.
        run_win("andf", 9'b000000000, 9'b111111111, 9'b000111000, 9'b000000000, 1'b0);
        check_eq("andf.err",    32'(cap_if.err_cnt),    32'd3);
        check_eq("andf.edge",   32'(cap_if.edge_cnt),   32'd1);
        check_eq("andf.sticky", 32'(cap_if.sticky_err), 32'd1);

        // q stuck at 0 while a toggles: a_p is 1 on compares 1,3,5,7.
        run_win("regf", 9'b101010101, 9'b111111111, 9'b101010101, 9'b000000000, 1'b0);
        check_eq("regf.err",    32'(cap_if.err_cnt),    32'd4);
        check_eq("regf.edge",   32'(cap_if.edge_cnt),   32'd4);
        check_eq("regf.sticky", 32'(cap_if.sticky_err), 32'd1);

        // Fault only on the final compare, with a start pulse mid-RUN that must be ignored.
        run_win("last", 9'b000000000, 9'b000000000, 9'b100000000, 9'b000000000, 1'b1);
        check_eq("last.err",    32'(cap_if.err_cnt),    32'd1);
        check_eq("last.edge",   32'(cap_if.edge_cnt),   32'd1);
        check_eq("last.sticky", 32'(cap_if.sticky_err), 32'd1);

        // Mid-run reset: y=1 with a&b=0 mismatches on every compare.
        @(negedge clk);
        cap_if.start = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        cap_if.start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mrst.pre_err",  32'(cap_if.err_cnt), 32'd3);
        check_eq("mrst.pre_busy", 32'(cap_if.busy),    32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mrst.busy",   32'(cap_if.busy),       32'd0);
        check_eq("mrst.done",   32'(cap_if.done),       32'd0);
        check_eq("mrst.sticky", 32'(cap_if.sticky_err), 32'd0);
        check_eq("mrst.err",    32'(cap_if.err_cnt),    32'd0);
        check_eq("mrst.edge",   32'(cap_if.edge_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_win("clean2", 9'b101110110, 9'b110111011, 9'b100110010, 9'b011101100, 1'b0);
        check_eq("clean2.err",    32'(cap_if.err_cnt),    32'd0);
        check_eq("clean2.edge",   32'(cap_if.edge_cnt),   32'd3);
        check_eq("clean2.sticky", 32'(cap_if.sticky_err), 32'd0);

        // Saturation: 20 mismatching compares into a 4-bit counter must stick at 15.
        @(negedge clk);
        sat_if.start  = 1'b1;
        sat_if.y_comb = 1'b1;
        @(negedge clk);
        sat_if.start = 1'b0;
        repeat (18) @(negedge clk);
        check_eq("sat.err_k18", 32'(sat_if.err_cnt), 32'd15);
        repeat (3) @(negedge clk);
        check_eq("sat.done_k21", 32'(sat_if.done), 32'd0);
        @(negedge clk);
        check_eq("sat.done_k22", 32'(sat_if.done),       32'd1);
        check_eq("sat.err",      32'(sat_if.err_cnt),    32'd15);
        check_eq("sat.edge",     32'(sat_if.edge_cnt),   32'd0);
        check_eq("sat.sticky",   32'(sat_if.sticky_err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
